// File: rtl/instr_mem_loader_if.sv
// rtl/instr_mem_loader_if.sv - byte stream and instruction memory port bundle for instr_mem_loader
//
// Signals:
//   byteIn[7:0], byteValid  source -> loader   stream byte and its valid
//   byteReady               loader -> source   loader takes the byte this cycle
//   memWrEn                 loader -> memory   single-cycle write strobe
//   memWrAddr[31:0]         loader -> memory   write byte address
//   memWrData[31:0]         loader -> memory   write word
//   memRdAddr[31:0]         loader -> memory   read-back address (INSTR_MEM_LOADER_READBACK_EN only)
//   memRdData[31:0]         memory -> loader   combinational read data (INSTR_MEM_LOADER_READBACK_EN only)
// Modports: slave = loader side, master = stream source / memory side.

interface instr_mem_loader_if;
  logic [7:0]  byteIn;
  logic        byteValid;
  logic        byteReady;
  logic        memWrEn;
  logic [31:0] memWrAddr;
  logic [31:0] memWrData;
`ifdef INSTR_MEM_LOADER_READBACK_EN
  logic [31:0] memRdAddr;
  logic [31:0] memRdData;

  modport slave (
    input  byteIn, byteValid, memRdData,
    output byteReady, memWrEn, memWrAddr, memWrData, memRdAddr
  );
  modport master (
    output byteIn, byteValid, memRdData,
    input  byteReady, memWrEn, memWrAddr, memWrData, memRdAddr
  );
`else
  modport slave (
    input  byteIn, byteValid,
    output byteReady, memWrEn, memWrAddr, memWrData
  );
  modport master (
    output byteIn, byteValid,
    input  byteReady, memWrEn, memWrAddr, memWrData
  );
`endif
endinterface

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - length-prefixed byte stream to instruction memory word writer
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   start        one-cycle pulse, begins a load from IDLE or DONE
//   bus          instr_mem_loader_if.slave: byte stream in, memory write port out
//   busy         high from an accepted start until DONE
//   done         sticky completion flag, cleared by the next accepted start
//   error        sticky error flag, meaningful when done=1
//   wordsLoaded  words written in the current or last load
// Macro INSTR_MEM_LOADER_READBACK_EN adds a VERIFY cycle after each write that
// compares memRdData at memRdAddr against the word just written.

module instr_mem_loader #(
  parameter int unsigned BASE_ADDR = 100,
  parameter int unsigned MAX_WORDS = 39
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  instr_mem_loader_if.slave   bus,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [7:0]          wordsLoaded
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN    = 3'd1,
    S_DATA   = 3'd2,
    S_WRITE  = 3'd3,
    S_CSUM   = 3'd4,
    S_DONE   = 3'd5
`ifdef INSTR_MEM_LOADER_READBACK_EN
    , S_VERIFY = 3'd6
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [1:0]  idx_q, idx_d;
  // Only the first three bytes of a word need holding; the fourth goes
  // straight into the write data register.
  logic [23:0] word_q, word_d;
  logic [7:0]  acc_q, acc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  words_q, words_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        ready;
  logic        wr_en;
  logic        xfer;

  assign xfer = bus.byteValid && ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= 8'd0;
      idx_q   <= 2'd0;
      word_q  <= 24'd0;
      acc_q   <= 8'd0;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      words_q <= 8'd0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      acc_q   <= acc_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      words_q <= words_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    word_d  = word_q;
    acc_d   = acc_q;
    addr_d  = addr_q;
    data_d  = data_q;
    words_d = words_q;
    done_d  = done_q;
    error_d = error_q;
    ready   = 1'b0;
    wr_en   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LEN;
          done_d  = 1'b0;
          error_d = 1'b0;
          words_d = 8'd0;
          acc_d   = 8'd0;
          idx_d   = 2'd0;
        end
      end

      S_LEN: begin
        ready = 1'b1;
        if (xfer) begin
          len_d = bus.byteIn;
          if (bus.byteIn == 8'd0 || bus.byteIn > 8'(MAX_WORDS)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            error_d = 1'b1;
          end else begin
            state_d = S_DATA;
            idx_d   = 2'd0;
          end
        end
      end

      S_DATA: begin
        ready = 1'b1;
        if (xfer) begin
          word_d = {word_q[15:0], bus.byteIn};
          acc_d  = acc_q ^ bus.byteIn;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            // Load address/data now so they are stable during the WRITE strobe
            // and keep their values afterwards.
            state_d = S_WRITE;
            addr_d  = 32'(BASE_ADDR) + {22'd0, words_q, 2'b00};
            data_d  = {word_q, bus.byteIn};
          end
        end
      end

      S_WRITE: begin
        wr_en   = 1'b1;
        words_d = words_q + 8'd1;
`ifdef INSTR_MEM_LOADER_READBACK_EN
        state_d = S_VERIFY;
`else
        state_d = (words_d == len_q) ? S_CSUM : S_DATA;
`endif
      end

`ifdef INSTR_MEM_LOADER_READBACK_EN
      S_VERIFY: begin
        // words_q already counts the word just written.
        if (bus.memRdData != data_q) error_d = 1'b1;
        state_d = (words_q == len_q) ? S_CSUM : S_DATA;
      end
`endif

      S_CSUM: begin
        ready = 1'b1;
        if (xfer) begin
          if (bus.byteIn != acc_q) error_d = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.byteReady = ready;
  assign bus.memWrEn   = wr_en;
  assign bus.memWrAddr = addr_q;
  assign bus.memWrData = data_q;
`ifdef INSTR_MEM_LOADER_READBACK_EN
  assign bus.memRdAddr = addr_q;
`endif

  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = done_q;
  assign error       = error_q;
  assign wordsLoaded = words_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - directed self-checking bench for instr_mem_loader

module tb_instr_mem_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] wordsLoaded;

  always #5 clk = ~clk;

  instr_mem_loader_if bus();

  instr_mem_loader #(.BASE_ADDR(100), .MAX_WORDS(39)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .wordsLoaded (wordsLoaded)
  );

  int          checks = 0;
  int          errors = 0;
  int          ready_viol = 0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [7:0]  stim[$];
  bit          gaps = 1'b0;

  // Write-port log, also flags any strobe that coincides with byteReady.
  always @(negedge clk) begin
    if (bus.memWrEn === 1'b1) begin
      wa_q.push_back(bus.memWrAddr);
      wd_q.push_back(bus.memWrData);
      if (bus.byteReady !== 1'b0) ready_viol++;
    end
  end

`ifdef INSTR_MEM_LOADER_READBACK_EN
  logic [31:0] mem [0:63];
  bit          corrupt_104 = 1'b0;
  always @(posedge clk) if (bus.memWrEn) mem[bus.memWrAddr[7:2]] <= bus.memWrData;
  assign bus.memRdData = mem[bus.memRdAddr[7:2]] ^
                         ((corrupt_104 && bus.memRdAddr == 32'd104) ? 32'h1 : 32'h0);
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  task automatic send_byte(input logic [7:0] b);
    int n;
    if (gaps) begin
      bus.byteValid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    bus.byteIn    = b;
    bus.byteValid = 1'b1;
    n = 0;
    while (bus.byteReady !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL byte_accept: byteReady low for %0d cycles, required transfer of %h", n, b);
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic send_stim();
    foreach (stim[i]) send_byte(stim[i]);
    bus.byteValid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL wait_done: done=%b after %0d cycles, required 1", done, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; bus.byteValid = 1'b0; bus.byteIn = 8'h00;
    @(negedge clk); @(negedge clk);
    checks++; if (bus.byteReady !== 1'b0) begin errors++; $display("FAIL rst_byteReady: got %b required 0", bus.byteReady); end
    checks++; if (bus.memWrEn !== 1'b0) begin errors++; $display("FAIL rst_memWrEn: got %b required 0", bus.memWrEn); end
    checks++; if (bus.memWrAddr !== 32'd0) begin errors++; $display("FAIL rst_memWrAddr: got %h required 0", bus.memWrAddr); end
    checks++; if (bus.memWrData !== 32'd0) begin errors++; $display("FAIL rst_memWrData: got %h required 0", bus.memWrData); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b required 0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL rst_error: got %b required 0", error); end
    checks++; if (wordsLoaded !== 8'd0) begin errors++; $display("FAIL rst_wordsLoaded: got %0d required 0", wordsLoaded); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    wa_q.delete(); wd_q.delete();
    pulse_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nom_busy: got %b required 1", busy); end
    stim = '{8'h02, 8'h8C, 8'h22, 8'h00, 8'h00, 8'h8C, 8'h23, 8'h00, 8'h04, 8'h05};
    send_stim();
    wait_done();
    checks++; if (wa_q.size() != 2) begin errors++; $display("FAIL nom_nwrites: got %0d required 2", wa_q.size()); end
    checks++; if (wa_q[0] !== 32'd100 || wd_q[0] !== 32'h8C220000) begin errors++; $display("FAIL nom_write0: got (%0d,%h) required (100,8c220000)", wa_q[0], wd_q[0]); end
    checks++; if (wa_q[1] !== 32'd104 || wd_q[1] !== 32'h8C230004) begin errors++; $display("FAIL nom_write1: got (%0d,%h) required (104,8c230004)", wa_q[1], wd_q[1]); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL nom_error: got %b required 0", error); end
    checks++; if (wordsLoaded !== 8'd2) begin errors++; $display("FAIL nom_words: got %0d required 2", wordsLoaded); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nom_busy_end: got %b required 0", busy); end
  endtask

  task automatic test_bad_checksum();
    logic [7:0] bad[2];
    bad[0] = 8'h07; bad[1] = 8'h06;
    for (int k = 0; k < 2; k++) begin
      wa_q.delete(); wd_q.delete();
      pulse_start();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL bad_done_clear: got %b required 0", done); end
      stim = '{8'h02, 8'h8C, 8'h22, 8'h00, 8'h00, 8'h8C, 8'h23, 8'h00, 8'h04};
      stim.push_back(bad[k]);
      send_stim();
      wait_done();
      checks++; if (wa_q.size() != 2) begin errors++; $display("FAIL bad_nwrites: got %0d required 2", wa_q.size()); end
      checks++; if (error !== 1'b1) begin errors++; $display("FAIL bad_error csum=%h: got %b required 1", bad[k], error); end
    end
  endtask

  task automatic test_illegal_len();
    logic [7:0] lens[2];
    lens[0] = 8'h00; lens[1] = 8'h28;
    for (int k = 0; k < 2; k++) begin
      wa_q.delete(); wd_q.delete();
      pulse_start();
      send_byte(lens[k]);
      checks++; if (done !== 1'b1 || error !== 1'b1) begin errors++; $display("FAIL ill_flags N=%h: got done=%b error=%b required 1/1", lens[k], done, error); end
      checks++; if (bus.byteReady !== 1'b0) begin errors++; $display("FAIL ill_ready N=%h: got %b required 0", lens[k], bus.byteReady); end
      bus.byteIn = 8'hAA;
      repeat (3) @(negedge clk);
      bus.byteValid = 1'b0;
      checks++; if (bus.byteReady !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ill_after N=%h: got ready=%b busy=%b required 0/0", lens[k], bus.byteReady, busy); end
      checks++; if (wa_q.size() != 0 || wordsLoaded !== 8'd0) begin errors++; $display("FAIL ill_writes N=%h: got %0d writes words=%0d required 0/0", lens[k], wa_q.size(), wordsLoaded); end
    end
  endtask

  task automatic test_max_len();
    logic [7:0] cs;
    wa_q.delete(); wd_q.delete();
    cs = 8'h00;
    stim = '{8'd39};
    for (int i = 0; i < 156; i++) begin
      stim.push_back(8'(i));
      cs = cs ^ 8'(i);
    end
    stim.push_back(cs);
    pulse_start();
    send_stim();
    wait_done();
    checks++; if (wa_q.size() != 39) begin errors++; $display("FAIL max_nwrites: got %0d required 39", wa_q.size()); end
    checks++; if (wa_q[38] !== 32'd252 || wd_q[38] !== 32'h98999A9B) begin errors++; $display("FAIL max_last: got (%0d,%h) required (252,98999a9b)", wa_q[38], wd_q[38]); end
    checks++; if (wordsLoaded !== 8'd39 || error !== 1'b0) begin errors++; $display("FAIL max_status: got words=%0d error=%b required 39/0", wordsLoaded, error); end
  endtask

  task automatic test_backpressure();
    wa_q.delete(); wd_q.delete(); ready_viol = 0;
    gaps = 1'b1;
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h4A);
    send_byte(8'h30);
    send_byte(8'h20);
    gaps = 1'b0;
    checks++; if (bus.memWrEn !== 1'b1 || bus.byteReady !== 1'b0) begin errors++; $display("FAIL bp_write_cycle: got wrEn=%b ready=%b required 1/0", bus.memWrEn, bus.byteReady); end
    checks++; if (bus.memWrAddr !== 32'd100 || bus.memWrData !== 32'h004A3020) begin errors++; $display("FAIL bp_write: got (%0d,%h) required (100,004a3020)", bus.memWrAddr, bus.memWrData); end
    bus.byteIn = 8'h5A; bus.byteValid = 1'b1;
    @(negedge clk);
    checks++; if (bus.memWrEn !== 1'b0 || bus.memWrAddr !== 32'd100 || bus.memWrData !== 32'h004A3020) begin errors++; $display("FAIL bp_hold: got wrEn=%b (%0d,%h) required 0 (100,004a3020)", bus.memWrEn, bus.memWrAddr, bus.memWrData); end
    send_byte(8'h5A);
    bus.byteValid = 1'b0;
    wait_done();
    checks++; if (wa_q.size() != 1 || error !== 1'b0) begin errors++; $display("FAIL bp_result: got %0d writes error=%b required 1/0", wa_q.size(), error); end
    checks++; if (ready_viol != 0) begin errors++; $display("FAIL bp_ready_in_write: got %0d overlaps required 0", ready_viol); end
  endtask

  task automatic test_reset_mid_word();
    wa_q.delete(); wd_q.delete();
    pulse_start();
    stim = '{8'h01, 8'h11, 8'h22};
    send_stim();
    reset = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || wordsLoaded !== 8'd0) begin errors++; $display("FAIL rmid_status: got busy=%b done=%b error=%b words=%0d required all 0", busy, done, error, wordsLoaded); end
    checks++; if (bus.byteReady !== 1'b0 || bus.memWrEn !== 1'b0 || bus.memWrAddr !== 32'd0 || bus.memWrData !== 32'd0) begin errors++; $display("FAIL rmid_bus: got ready=%b wrEn=%b addr=%h data=%h required all 0", bus.byteReady, bus.memWrEn, bus.memWrAddr, bus.memWrData); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (wa_q.size() != 0) begin errors++; $display("FAIL rmid_nowrite: got %0d writes required 0", wa_q.size()); end
    pulse_start();
    stim = '{8'h02, 8'h8C, 8'h22, 8'h00, 8'h00, 8'h8C, 8'h23, 8'h00, 8'h04, 8'h05};
    send_stim();
    wait_done();
    checks++; if (wa_q.size() != 2 || wa_q[0] !== 32'd100 || wd_q[0] !== 32'h8C220000) begin errors++; $display("FAIL rmid_reload: got %0d writes first (%0d,%h) required 2 (100,8c220000)", wa_q.size(), wa_q[0], wd_q[0]); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL rmid_error: got %b required 0", error); end
  endtask

  task automatic test_start_while_busy();
    wa_q.delete(); wd_q.delete();
`ifdef INSTR_MEM_LOADER_READBACK_EN
    corrupt_104 = 1'b1;
`endif
    pulse_start();
    stim = '{8'h02, 8'h8C, 8'h22};
    send_stim();
    pulse_start();
    checks++; if (busy !== 1'b1 || bus.byteReady !== 1'b1) begin errors++; $display("FAIL swb_state: got busy=%b ready=%b required 1/1", busy, bus.byteReady); end
    stim = '{8'h00, 8'h00, 8'h8C, 8'h23, 8'h00, 8'h04, 8'h05};
    send_stim();
    wait_done();
    checks++; if (wa_q.size() != 2 || wd_q[0] !== 32'h8C220000 || wd_q[1] !== 32'h8C230004) begin errors++; $display("FAIL swb_writes: got %0d writes %h %h required 2 8c220000 8c230004", wa_q.size(), wd_q[0], wd_q[1]); end
    checks++; if (wordsLoaded !== 8'd2) begin errors++; $display("FAIL swb_words: got %0d required 2", wordsLoaded); end
    checks++; if (error !== READBACK) begin errors++; $display("FAIL swb_error: got %b required %b", error, READBACK); end
`ifdef INSTR_MEM_LOADER_READBACK_EN
    corrupt_104 = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_bad_checksum();
    test_illegal_len();
    test_max_len();
    test_backpressure();
    test_reset_mid_word();
    test_start_while_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
